dmem_responder: RTL

Memory-side responder for the pipeline's load/store port. It accepts one read or write request from the MEM stage and performs byte, half or word access with a configurable number of wait states. It returns sign- or zero-extended load data with a one-cycle `ack`, and drives `stall` so the hazard unit can freeze the pipeline until the access completes. It replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder_lane_align.sv | 42 ++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and access-legality rule for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } acc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsupported modes, misaligned halves/words and unsigned stores are rejected.
  function automatic logic acc_illegal(logic [2:0] mode, logic [1:0] addr_lo, logic is_store);
    logic bad;
    case (mode)
      MEM_B, MEM_BU: bad = 1'b0;
      MEM_H, MEM_HU: bad = addr_lo[0];
      MEM_W:         bad = (addr_lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad | (is_store & mode[2]);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the memory responder (slave).
interface dmem_responder_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mem_acc_mode;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output rd_en, wr_en, addr, wdata, mem_acc_mode,
    input  rdata, ack, err, stall
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata, mem_acc_mode,
    output rdata, ack, err, stall
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated write word and
// right-aligned, sign/zero-extended load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_mode,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte   = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half   = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    w_signed = ~i_mode[2];
    o_strb   = 4'b1111;
    o_wword  = i_wdata;
    o_rdata  = i_rword;
    // Write data is replicated across lanes so the strobe alone picks the target.
    case (i_mode[1:0])
      2'b00: begin
        o_strb  = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_strb  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store, waits WAIT_CYCLES, then
// answers with a one-cycle ack while stall freezes the pipeline.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_rd;
  logic          r_wr;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_mode;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_idle;
  logic          w_req;
  logic          w_rd;
  logic          w_wr;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_mode;
  logic          w_err;
  logic          w_enter_resp;
  logic [31:0]   w_rword;
  logic [3:0]    w_strb;
  logic [31:0]   w_wword;
  logic [31:0]   w_ldata;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = bus.rd_en | bus.wr_en;

  // With zero wait states the response is built straight from the live request.
  assign w_rd    = w_idle ? bus.rd_en : r_rd;
  assign w_wr    = w_idle ? bus.wr_en : r_wr;
  assign w_addr  = w_idle ? bus.addr[AW+1:0] : r_addr;
  assign w_wdata = w_idle ? bus.wdata : r_wdata;
  assign w_mode  = w_idle ? bus.mem_acc_mode : r_mode;

  assign w_err   = (w_rd & w_wr) | acc_illegal(w_mode, w_addr[1:0], w_wr);
  assign w_rword = r_mem[w_addr[AW+1:2]];

  assign w_enter_resp = (w_idle & w_req & (WAIT_CYCLES == 0)) |
                        ((r_state == S_WAIT) & (r_cnt == 4'd0));

  dmem_lane_align u_align (
    .i_addr_lo (w_addr[1:0]),
    .i_mode    (w_mode),
    .i_wdata   (w_wdata),
    .i_rword   (w_rword),
    .o_strb    (w_strb),
    .o_wword   (w_wword),
    .o_rdata   (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mode  <= 3'b000;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_rd    <= bus.rd_en;
            r_wr    <= bus.wr_en;
            r_addr  <= bus.addr[AW+1:0];
            r_wdata <= bus.wdata;
            r_mode  <= bus.mem_acc_mode;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_resp) begin
        r_ack   <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_err | w_wr) ? 32'd0 : w_ldata;
      end
    end
  end

  // Store commits on the edge that ends RESP; reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_RESP) && r_wr && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[r_addr[AW+1:2]][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  assign bus.stall = (w_idle & w_req) | (r_state == S_WAIT);
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule
